// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed stores sitting between MEM and the
// single-port data cache. Stores enter in one cycle and drain one per cycle
// whenever no load is looking up. Loads search youngest-to-oldest; a fully
// covering entry forwards data, a partial overlap raises a conflict.

// Per-entry overlap/cover test against the current load.
module sb_match #(
  parameter int AW = 32
) (
  input  logic          vld,
  input  logic [AW-3:0] ewd,
  input  logic [3:0]    emask,
  input  logic [AW-3:0] lwd,
  input  logic [3:0]    lmask,
  output logic          ovl,
  output logic          cov
);
  assign ovl = vld && (ewd == lwd) && (|(emask & lmask));
  assign cov = ((emask & lmask) == lmask);
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [2:0]               st_memop,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [2:0]               ld_memop,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic                     ld_conflict,
  output logic                     mem_wen,
  output logic [2:0]               mem_memop,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    memop;
    logic [31:0]   data;
    logic [3:0]    mask;
    logic [31:0]   lane;
  } ent_t;

  // Byte-enable mask; unsigned loads reuse the signed masks, illegal ops get 0.
  function automatic logic [3:0] mask_of(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: mask_of = 4'b0001 << a;
      3'b001, 3'b101: mask_of = a[1] ? 4'b1100 : 4'b0011;
      3'b010:         mask_of = 4'b1111;
      default:        mask_of = 4'b0000;
    endcase
  endfunction

  // Replicate the right-justified store data into every byte lane it may hit.
  function automatic logic [31:0] lane_of(input logic [2:0] op, input logic [31:0] d);
    case (op[1:0])
      2'b00:   lane_of = {4{d[7:0]}};
      2'b01:   lane_of = {2{d[15:0]}};
      default: lane_of = d;
    endcase
  endfunction

  ent_t             ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;

  logic st_legal, enq, pop, full;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign st_ready = !full;
  assign st_legal = (st_memop == 3'b000) ||
                    (st_memop == 3'b001 && !st_addr[0]) ||
                    (st_memop == 3'b010 && st_addr[1:0] == 2'b00);
  assign enq      = st_valid && st_ready && st_legal;
  // Loads own the cache port, so drain only in load-free cycles.
  assign pop      = !empty && !ld_valid;

  assign mem_wen   = pop;
  assign mem_memop = ent[rptr].memop;
  assign mem_addr  = ent[rptr].addr;
  assign mem_data  = ent[rptr].data;

  // Control state: valid bits, pointers, occupancy and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= st_valid && st_ready && !st_legal;
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      if (enq) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      case ({enq, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload; no reset needed since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent[wptr].addr  <= st_addr;
      ent[wptr].memop <= st_memop;
      ent[wptr].data  <= st_data;
      ent[wptr].mask  <= mask_of(st_memop, st_addr[1:0]);
      ent[wptr].lane  <= lane_of(st_memop, st_data);
    end
  end

  // Lookup: one comparator per entry.
  logic [3:0]       ld_mask;
  logic [DEPTH-1:0] ovl, cov;

  assign ld_mask = mask_of(ld_memop, ld_addr[1:0]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    sb_match #(.AW(AW)) u_match (
      .vld   (vld[i]),
      .ewd   (ent[i].addr[AW-1:2]),
      .emask (ent[i].mask),
      .lwd   (ld_addr[AW-1:2]),
      .lmask (ld_mask),
      .ovl   (ovl[i]),
      .cov   (cov[i])
    );
  end

  logic          sel_ovl, sel_cov;
  logic [PW-1:0] sel_idx, idx;

  // Walk oldest to youngest so the youngest overlapping entry wins.
  always_comb begin
    sel_ovl = 1'b0;
    sel_cov = 1'b0;
    sel_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (ovl[idx]) begin
        sel_ovl = 1'b1;
        sel_cov = cov[idx];
        sel_idx = idx;
      end
    end
  end

  logic [31:0] sel_word, ext;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sel_word = ent[sel_idx].lane;
  assign sel_b    = sel_word[{ld_addr[1:0], 3'b000} +: 8];
  assign sel_h    = ld_addr[1] ? sel_word[31:16] : sel_word[15:0];

  // Extend the selected lanes according to the load type.
  always_comb begin
    case (ld_memop)
      3'b000:  ext = {{24{sel_b[7]}}, sel_b};
      3'b001:  ext = {{16{sel_h[15]}}, sel_h};
      3'b010:  ext = sel_word;
      3'b100:  ext = {24'h0, sel_b};
      3'b101:  ext = {16'h0, sel_h};
      default: ext = 32'h0;
    endcase
  end

  assign ld_hit      = ld_valid && sel_ovl && sel_cov;
  assign ld_conflict = ld_valid && sel_ovl && !sel_cov;
  assign ld_data     = ld_hit ? ext : 32'h0;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of committed stores between the MEM stage and the single-port data cache.
- Stores retire into the buffer in one cycle and drain to the cache one per cycle, only in cycles with no load.
- Loads in flight search the buffer: a full byte coverage by the youngest matching store forwards data, and a partial overlap raises a conflict so the pipeline stalls.
- memop encoding matches the data cache: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.

Parameters:
- DEPTH, 4, number of entries (power of two, >=2)
- AW, 32, address width

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from MEM stage
- st_memop  in  3  store size (000/001/010 only)
- st_addr  in  AW  byte address
- st_data  in  32  store data, right-justified
- st_ready  out  1  buffer can accept (= !full)
- st_err  out  1  registered 1-cycle pulse: illegal memop or misaligned store dropped
- ld_valid  in  1  load lookup this cycle
- ld_memop  in  3  load type
- ld_addr  in  AW  byte address
- ld_hit  out  1  combinational: forwarding valid
- ld_data  out  32  combinational: forwarded, extended data (0 when !ld_hit)
- ld_conflict  out  1  combinational: partial overlap, requester must stall
- mem_wen  out  1  cache write enable (combinational)
- mem_memop  out  3  head entry memop
- mem_addr  out  AW  head entry address
- mem_data  out  32  head entry original st_data
- empty  out  1  no valid entries
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0): all valid bits, pointers and count cleared; st_ready=1, empty=1, count=0, mem_wen=0, st_err=0, ld_hit=0, ld_conflict=0, ld_data=0. Reset mid-drain discards all pending stores.
- Entry contents: addr, memop, raw data, word address addr[AW-1:2], byte mask, lane-aligned data word.
- Byte mask by size:
  - sb: 1<<addr[1:0]
  - sh: 0011 or 1100 by addr[1]
  - sw: 1111
- Lane data: lane i = st_data[7:0] for sb; st_data[8*(i%2)+:8] for sh; st_data[8*i+:8] for sw.
- Enqueue: at posedge when st_valid && st_ready && legal; entry is visible to lookup and drain from the next cycle. There is no same-cycle bypass.
- Illegal cases: memop not in {000,001,010}, sh with addr[0]=1, or sw with addr[1:0]!=0. These are not enqueued; st_err=1 for exactly the following cycle.
- Drain: mem_wen = !empty && !ld_valid. The head entry's fields drive mem_* and are stable for the whole cycle. The head is popped at the posedge where mem_wen=1.
- Loads have strict priority over drain, so a continuous ld_valid starves drain.
- Simultaneous enqueue and pop in the same cycle: count unchanged, both pointers advance.
- Full: st_ready=0; st_valid is ignored and the producer holds the request.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Lookup (ld_valid=1): load mask from ld_memop/ld_addr, same rules as stores; 100/101 use the byte/half masks.
  - An entry overlaps when it is valid, its word address equals ld_addr word, and (mask & ldmask) != 0.
  - Search is youngest to oldest. If the youngest overlapping entry's mask covers ldmask, then ld_hit=1 and ld_data = selected lanes, sign-extended (000/001) or zero-extended (100/101).
  - If an overlap exists without full cover, ld_conflict=1 and ld_hit=0.
  - With no overlap, both are 0 and the load reads the cache.
  - ld_valid=0 forces ld_hit=ld_conflict=0.
- Illegal ld_memop (011/110/111): ld_hit=ld_conflict=0, ld_data=0.
- A conflicting load stalls the pipeline (ld_valid held), which blocks drain. The pipeline controller must drop ld_valid for at least one cycle to let drain progress; the buffer does not arbitrate.

Test Plan:
- Reset, then sw addr 0x100 data 0xDEADBEEF -> next cycle count=1, empty=0. With ld_valid=0: mem_wen=1, mem_addr=0x100, mem_memop=010, mem_data=0xDEADBEEF; the following cycle empty=1.
- Fill 4 stores with ld_valid held high -> st_ready=0 after 4th. A 5th st_valid is ignored and count stays 4. Drop ld_valid -> 4 drains in FIFO order over 4 cycles, count 4→0.
- sb 0x203 data 0x80 buffered; lb 0x203 -> ld_hit=1, ld_data=0xFFFFFF80. lbu 0x203 -> ld_data=0x00000080. lw 0x200 -> ld_conflict=1, ld_hit=0.
- sw 0x300=0x11223344 then sh 0x302=0xAABB; lh 0x302 -> ld_data=0xFFFFAABB (youngest wins). lh 0x300 -> ld_data=0x00003344 (sw covers). lw 0x300 -> ld_conflict=1.
- sh addr 0x401 and memop 011 -> neither enqueued, st_err pulses 1 cycle each, count unchanged.
- Count=DEPTH-1 with enqueue and pop in the same cycle -> count unchanged, pointers wrap correctly. Assert rst_n low mid-drain -> mem_wen=0 immediately, count=0.
